// File: rtl/chess_pkg.sv
// chess_pkg: shared types and constants for the chessboard controller.
//   piece_t    4-bit piece code, bit 3 = colour (1 black), bits 2:0 = type
//   ptype_t    piece type values (EMPTY..KING)
//   square_t   6-bit square index, col + 8*row, row 0 at screen top
//   INIT_BOARD starting position, element n is square n
//   state_t    move sequencer states
package chess_pkg;

    typedef logic [3:0] piece_t;
    typedef logic [5:0] square_t;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } ptype_t;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    // Packed with square 63 in the top nibble: black back rank and pawns
    // occupy rows 0-1, white pawns and back rank occupy rows 6-7.
    localparam logic [63:0][3:0] INIT_BOARD = {
        32'h4236_5324,   // row 7, squares 63..56
        32'h1111_1111,   // row 6
        128'h0,          // rows 5..2
        32'h9999_9999,   // row 1
        32'hCABE_DBAC    // row 0, squares 7..0
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE
    } state_t;

endpackage

// File: rtl/board_ctl_if.sv
// board_ctl_if: move request handshakes from the two players.
//   loc_*  local (mouse) requester: valid, ready, src, dst
//   rem_*  remote (UART) requester: valid, ready, src, dst
// master = requester side, slave = board_ctl side.
interface board_ctl_if;
    import chess_pkg::*;

    logic    loc_valid;
    logic    loc_ready;
    square_t loc_src;
    square_t loc_dst;
    logic    rem_valid;
    logic    rem_ready;
    square_t rem_src;
    square_t rem_dst;

    modport master (
        output loc_valid, loc_src, loc_dst, rem_valid, rem_src, rem_dst,
        input  loc_ready, rem_ready
    );

    modport slave (
        input  loc_valid, loc_src, loc_dst, rem_valid, rem_src, rem_dst,
        output loc_ready, rem_ready
    );

endinterface

// File: rtl/board_mem.sv
// board_mem: 64 x 4-bit chessboard register file.
//   clk           system clock
//   init          load the starting position (also clears the display read)
//   rd_src/rd_dst combinational read pair -> src_piece/dst_piece
//   disp_addr     registered display read -> disp_piece (1-cycle latency)
//   we            write enable: wr_dst <- wr_dst_piece, wr_src <- empty
module board_mem
    import chess_pkg::*;
(
    input  logic    clk,
    input  logic    init,
    input  square_t rd_src,
    input  square_t rd_dst,
    output piece_t  src_piece,
    output piece_t  dst_piece,
    input  square_t disp_addr,
    output piece_t  disp_piece,
    input  logic    we,
    input  square_t wr_src,
    input  square_t wr_dst,
    input  piece_t  wr_dst_piece
);

    piece_t [63:0] board;

    assign src_piece = board[rd_src];
    assign dst_piece = board[rd_dst];

    // The display samples the board before this edge's write lands, so a
    // square being written reads back its old value for one cycle.
    always_ff @(posedge clk) begin
        if (init) begin
            board      <= INIT_BOARD;
            disp_piece <= '0;
        end else begin
            disp_piece <= board[disp_addr];
            if (we) begin
                // src and dst are distinct for any move that reaches a write
                board[wr_dst] <= wr_dst_piece;
                board[wr_src] <= '0;
            end
        end
    end

endmodule

// File: rtl/board_ctl.sv
// board_ctl: chessboard owner and move sequencer.
//   clk, rst        clock, synchronous active-high reset
//   new_game        synchronous return to the starting position
//   figure_xy       display read address
//   piece_code      registered piece at figure_xy
//   mv              local/remote move handshakes (board_ctl_if.slave)
//   turn            colour to move (0 white)
//   move_done       1-cycle pulse, move committed
//   move_err        1-cycle pulse, move rejected
//   game_over       sticky, a king was captured
module board_ctl
    import chess_pkg::*;
#(
    parameter logic LOCAL_COLOR = 1'b0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  square_t    figure_xy,
    output piece_t     piece_code,
    board_ctl_if.slave mv,
    output logic       turn,
    output logic       move_done,
    output logic       move_err,
    output logic       game_over
);

    state_t  state;
    square_t src_q, dst_q;
    piece_t  src_piece, dst_piece, wr_piece;
    logic    loc_ready_q, rem_ready_q;
    logic    clear, loc_hs, rem_hs, legal, promote, king_taken;

    assign clear = rst || new_game;

    assign mv.loc_ready = loc_ready_q;
    assign mv.rem_ready = rem_ready_q;

    // Only the requester whose colour is on move ever sees ready, so at
    // most one handshake can fire per cycle.
    assign loc_hs = mv.loc_valid && loc_ready_q;
    assign rem_hs = mv.rem_valid && rem_ready_q;

    assign legal = (src_q != dst_q)
                && (src_piece[2:0] != EMPTY)
                && (src_piece[3] == turn)
                && ((dst_piece[2:0] == EMPTY) || (dst_piece[3] != turn));

    assign promote = (src_piece[2:0] == PAWN)
                  && (((src_piece[3] == WHITE) && (dst_q[5:3] == 3'd0))
                   || ((src_piece[3] == BLACK) && (dst_q[5:3] == 3'd7)));

    assign wr_piece   = promote ? {src_piece[3], QUEEN} : src_piece;
    assign king_taken = (dst_piece[2:0] == KING);

    // {rem_ready, loc_ready} for an IDLE with the given turn / game state
    function automatic logic [1:0] rdy(input logic t, input logic go);
        if (go)
            return 2'b00;
        return (t == LOCAL_COLOR) ? 2'b01 : 2'b10;
    endfunction

    board_mem u_mem (
        .clk          (clk),
        .init         (clear),
        .rd_src       (src_q),
        .rd_dst       (dst_q),
        .src_piece    (src_piece),
        .dst_piece    (dst_piece),
        .disp_addr    (figure_xy),
        .disp_piece   (piece_code),
        .we           ((state == ST_WRITE) && !clear),
        .wr_src       (src_q),
        .wr_dst       (dst_q),
        .wr_dst_piece (wr_piece)
    );

    always_ff @(posedge clk) begin
        move_done <= 1'b0;
        move_err  <= 1'b0;
        if (clear) begin
            state                      <= ST_IDLE;
            turn                       <= WHITE;
            game_over                  <= 1'b0;
            {rem_ready_q, loc_ready_q} <= 2'b00;
            src_q                      <= '0;
            dst_q                      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (loc_hs || rem_hs) begin
                        src_q                      <= loc_hs ? mv.loc_src : mv.rem_src;
                        dst_q                      <= loc_hs ? mv.loc_dst : mv.rem_dst;
                        {rem_ready_q, loc_ready_q} <= 2'b00;
                        state                      <= ST_CHECK;
                    end else begin
                        {rem_ready_q, loc_ready_q} <= rdy(turn, game_over);
                    end
                end
                ST_CHECK: begin
                    if (legal) begin
                        state <= ST_WRITE;
                    end else begin
                        move_err                   <= 1'b1;
                        state                      <= ST_IDLE;
                        {rem_ready_q, loc_ready_q} <= rdy(turn, game_over);
                    end
                end
                ST_WRITE: begin
                    // dst_piece still shows the captured piece here; the
                    // board write lands on this same edge.
                    state     <= ST_IDLE;
                    turn      <= ~turn;
                    move_done <= 1'b1;
                    if (king_taken)
                        game_over <= 1'b1;
                    {rem_ready_q, loc_ready_q} <= rdy(~turn, game_over || king_taken);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_ctl.sv
module tb_board_ctl;

    localparam logic LOCAL_COLOR = 1'b0;

    logic       clk = 1'b0;
    logic       rst, new_game;
    logic [5:0] figure_xy;
    logic [3:0] piece_code;
    logic       turn, move_done, move_err, game_over;

    board_ctl_if bif();

    board_ctl #(.LOCAL_COLOR(LOCAL_COLOR)) dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .figure_xy  (figure_xy),
        .piece_code (piece_code),
        .mv         (bif),
        .turn       (turn),
        .move_done  (move_done),
        .move_err   (move_err),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: the board as a plain array ----------
    logic [3:0] mb [64];
    logic       mturn, mgo;

    task automatic m_reset();
        logic [3:0] back_b [8];
        logic [3:0] back_w [8];
        back_b = '{4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC};
        back_w = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
        for (int c = 0; c < 8; c++) begin
            mb[c]      = back_b[c];
            mb[8 + c]  = 4'h9;
            for (int r = 2; r < 6; r++) mb[r*8 + c] = 4'h0;
            mb[48 + c] = 4'h1;
            mb[56 + c] = back_w[c];
        end
        mturn = 1'b0;
        mgo   = 1'b0;
    endtask

    function automatic bit m_legal(input int s, input int d);
        logic [3:0] ps, pd;
        ps = mb[s];
        pd = mb[d];
        return (s != d) && (ps[2:0] != 3'd0) && (ps[3] == mturn)
            && ((pd[2:0] == 3'd0) || (pd[3] != mturn));
    endfunction

    task automatic m_apply(input int s, input int d);
        logic [3:0] p, pd;
        p  = mb[s];
        pd = mb[d];
        if (p[2:0] == 3'd1 && ((!p[3] && d / 8 == 0) || (p[3] && d / 8 == 7)))
            p = {p[3], 3'd5};
        if (pd[2:0] == 3'd6) mgo = 1'b1;
        mb[d] = p;
        mb[s] = 4'h0;
        mturn = !mturn;
    endtask

    // ---------------- helpers (all entered and left at a negedge) ----------
    task automatic read_sq(input logic [5:0] sq, output logic [3:0] code);
        figure_xy = sq;
        @(negedge clk);
        code = piece_code;
    endtask

    task automatic check_board(input string tag);
        for (int sq = 0; sq < 64; sq++) begin
            figure_xy = sq[5:0];
            @(negedge clk);
            chk($sformatf("%s_sq%0d", tag, sq), piece_code, mb[sq]);
        end
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        m_reset();
        @(negedge clk);
    endtask

    task automatic drop_valids();
        bif.loc_valid = 1'b0;
        bif.rem_valid = 1'b0;
    endtask

    task automatic do_move(input bit rem, input logic [5:0] s, input logic [5:0] d,
                           input bit noise, output bit ok_seen);
        int         n;
        bit         exp_ok;
        logic [3:0] old_d;
        n       = 0;
        ok_seen = 1'b0;
        if (rem) begin
            bif.rem_valid = 1'b1; bif.rem_src = s; bif.rem_dst = d;
            if (noise) begin
                bif.loc_valid = 1'b1;
                bif.loc_src = 6'($urandom_range(63));
                bif.loc_dst = 6'($urandom_range(63));
            end
        end else begin
            bif.loc_valid = 1'b1; bif.loc_src = s; bif.loc_dst = d;
            if (noise) begin
                bif.rem_valid = 1'b1;
                bif.rem_src = 6'($urandom_range(63));
                bif.rem_dst = 6'($urandom_range(63));
            end
        end
        while ((rem ? bif.rem_ready : bif.loc_ready) !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("hs_ready", rem ? bif.rem_ready : bif.loc_ready, 1);
        if ((rem ? bif.rem_ready : bif.loc_ready) !== 1'b1) begin
            drop_valids();
            return;
        end
        exp_ok = m_legal(s, d);
        old_d  = mb[d];
        @(posedge clk);                       // handshake edge
        @(negedge clk);
        drop_valids();
        chk("busy_loc_ready", bif.loc_ready, 0);
        chk("busy_rem_ready", bif.rem_ready, 0);
        chk("check_no_pulse", {move_done, move_err}, 0);
        @(negedge clk);                       // after the CHECK edge
        chk("move_err", move_err, !exp_ok);
        chk("done_early", move_done, 0);
        if (exp_ok) begin
            figure_xy = d;
            @(negedge clk);                   // after the WRITE edge
            chk("move_done", move_done, 1);
            chk("err_on_legal", move_err, 0);
            chk("disp_prewrite", piece_code, old_d);
            ok_seen = move_done;
            m_apply(s, d);
            @(negedge clk);
            chk("disp_postwrite", piece_code, mb[d]);
            chk("done_one_cycle", move_done, 0);
        end else begin
            ok_seen = !move_err;
        end
        chk("turn", turn, mturn);
        chk("game_over", game_over, mgo);
        chk("loc_ready", bif.loc_ready, !mgo && (mturn == LOCAL_COLOR));
        chk("rem_ready", bif.rem_ready, !mgo && (mturn != LOCAL_COLOR));
    endtask

    task automatic run_random(input int nmoves);
        int         cand[$];
        logic [5:0] s, d;
        bit         ok;
        for (int i = 0; i < nmoves; i++) begin
            if (mgo) do_new_game();
            cand.delete();
            for (int sq = 0; sq < 64; sq++)
                if (mb[sq] != 4'h0 && mb[sq][3] == mturn) cand.push_back(sq);
            if ($urandom_range(3) != 0 && cand.size() > 0)
                s = 6'(cand[$urandom_range(cand.size() - 1)]);
            else
                s = 6'($urandom_range(63));
            d = 6'($urandom_range(63));
            do_move(mturn != LOCAL_COLOR, s, d, 1'($urandom_range(1)), ok);
            if (i % 30 == 29) check_board("rnd");
        end
    endtask

    // ---------------- directed table ----------------------------------------
    typedef struct {
        bit         ng;     // new_game before this move
        bit         rem;
        logic [5:0] s;
        logic [5:0] d;
        bit         ok;
        logic [3:0] code;   // piece at d afterwards
        bit         trn;
        bit         go;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] code;
        bit         ok;

        tbl[0]  = '{1'b0, 1'b0, 6'd52, 6'd36, 1'b1, 4'h1, 1'b1, 1'b0}; // e2-e4
        tbl[1]  = '{1'b0, 1'b1, 6'd20, 6'd28, 1'b0, 4'h0, 1'b1, 1'b0}; // empty src
        tbl[2]  = '{1'b0, 1'b1, 6'd12, 6'd12, 1'b0, 4'h9, 1'b1, 1'b0}; // src==dst
        tbl[3]  = '{1'b0, 1'b1, 6'd11, 6'd3,  1'b0, 4'hD, 1'b1, 1'b0}; // own piece at dst
        tbl[4]  = '{1'b0, 1'b1, 6'd51, 6'd43, 1'b0, 4'h0, 1'b1, 1'b0}; // wrong colour
        tbl[5]  = '{1'b0, 1'b1, 6'd12, 6'd28, 1'b1, 4'h9, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 6'd59, 6'd12, 1'b1, 4'h5, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 6'd1,  6'd16, 1'b1, 4'hA, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 6'd12, 6'd4,  1'b1, 4'h5, 1'b1, 1'b1}; // king taken
        tbl[9]  = '{1'b1, 1'b0, 6'd48, 6'd8,  1'b1, 4'h1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 6'd0,  6'd24, 1'b1, 4'hC, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 6'd8,  6'd0,  1'b1, 4'h5, 1'b1, 1'b0}; // white promo
        tbl[12] = '{1'b0, 1'b1, 6'd9,  6'd56, 1'b1, 4'hD, 1'b0, 1'b0}; // black promo

        rst = 1'b1; new_game = 1'b0; figure_xy = 6'd0;
        bif.loc_valid = 1'b0; bif.loc_src = '0; bif.loc_dst = '0;
        bif.rem_valid = 1'b0; bif.rem_src = '0; bif.rem_dst = '0;
        m_reset();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_piece_code", piece_code, 0);
        chk("rst_loc_ready", bif.loc_ready, 0);
        chk("rst_rem_ready", bif.rem_ready, 0);
        chk("rst_turn", turn, 0);
        chk("rst_pulses", {move_done, move_err}, 0);
        chk("rst_game_over", game_over, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_loc_ready", bif.loc_ready, 1);
        chk("post_rst_rem_ready", bif.rem_ready, 0);
        check_board("reset");

        // off-turn requester is held off without an error
        bif.rem_valid = 1'b1; bif.rem_src = 6'd12; bif.rem_dst = 6'd20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("offturn_rem_ready", bif.rem_ready, 0);
            chk("offturn_pulses", {move_done, move_err}, 0);
        end
        bif.rem_valid = 1'b0;
        chk("offturn_turn", turn, 0);

        // directed move table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].ng) do_new_game();
            do_move(tbl[i].rem, tbl[i].s, tbl[i].d, 1'b0, ok);
            chk($sformatf("tbl%0d_outcome", i), ok, tbl[i].ok);
            read_sq(tbl[i].d, code);
            chk($sformatf("tbl%0d_code", i), code, tbl[i].code);
            chk($sformatf("tbl%0d_turn", i), turn, tbl[i].trn);
            chk($sformatf("tbl%0d_go", i), game_over, tbl[i].go);
        end
        check_board("tbl");

        // randomized play against the model
        run_random(120);
        check_board("rnd_end");

        // new_game in the cycle after a handshake discards the move
        do_new_game();
        bif.loc_valid = 1'b1; bif.loc_src = 6'd52; bif.loc_dst = 6'd36;
        chk("ng_hs_ready", bif.loc_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bif.loc_valid = 1'b0;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("ng_pulses_a", {move_done, move_err}, 0);
        chk("ng_turn", turn, 0);
        chk("ng_game_over", game_over, 0);
        @(negedge clk);
        chk("ng_pulses_b", {move_done, move_err}, 0);
        chk("ng_loc_ready", bif.loc_ready, 1);
        chk("ng_rem_ready", bif.rem_ready, 0);
        @(negedge clk);
        chk("ng_pulses_c", {move_done, move_err}, 0);
        m_reset();
        check_board("ng");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
